sbox_gen_ctrl: RTL and testbench

//   Sequencer for the chaotic S-box generation pipeline (read -> extractor -> mixer -> seen -> sbox).

---
 rtl/sbox_pkg.sv | 23 ++
 rtl/sat_counter.sv | 41 ++++
 rtl/sbox_gen_ctrl.sv | 140 ++++++++++++++
 tb/tb_sbox_gen_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_pkg.sv
// +--------------------------------------------------------------------+
// | sbox_pkg : shared state encoding and table geometry for S-box gen   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package sbox_pkg;

  localparam int SBOX_SIZE = 256;
  localparam int SBOX_AW   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PRIME   = 3'd2,
    ST_COLLECT = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAIL    = 3'd5
  } sbox_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +--------------------------------------------------------------------+
// | sat_counter : up-counter with clear that stops at MAX, flags MAX    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_max
);

  localparam logic [W-1:0] c_MAX = W'(MAX);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == c_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_max = w_at_max;

endmodule

`default_nettype wire

// File: rtl/sbox_gen_ctrl.sv
// +--------------------------------------------------------------------+
// | sbox_gen_ctrl : sequencer for chaotic S-box generation pipeline     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module sbox_gen_ctrl
  import sbox_pkg::*;
#(
  parameter int PIPE_DEPTH  = 3,
  parameter int MAX_SAMPLES = 4096,
  parameter int SAMPLE_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_cand_seen,
  output logic                o_gen_en,
  output logic                o_seen_clr,
  output logic                o_wr_en,
  output logic [SBOX_AW-1:0]  o_wr_addr,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_fail,
  output logic [SAMPLE_W-1:0] o_sample_cnt
);

  localparam int                c_PRIME_W     = $clog2(PIPE_DEPTH + 1);
  localparam logic [SBOX_AW:0]  c_FILL_LAST   = (SBOX_AW+1)'(SBOX_SIZE - 1);
  localparam logic [SBOX_AW:0]  c_FILL_FULL   = (SBOX_AW+1)'(SBOX_SIZE);
  localparam logic [SAMPLE_W-1:0] c_SAMPLE_LAST = SAMPLE_W'(MAX_SAMPLES - 1);

  sbox_ctrl_state_t r_state;
  sbox_ctrl_state_t w_state_nxt;

  logic [SBOX_AW:0]    r_fill_cnt;
  logic                w_idle_like;
  logic                w_start_ok;
  logic                w_wr;
  logic                w_sample;
  logic                w_prime_inc;
  logic                w_prime_max;
  logic [c_PRIME_W-1:0] w_prime_cnt;
  logic [SAMPLE_W-1:0] w_sample_cnt;
  logic                w_sample_max;
  logic                w_timeout;
  logic                w_last_entry;
  logic                w_unused;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL);
  assign w_start_ok  = i_start && !i_abort && w_idle_like;

  // Abort masks every side effect of the cycle it arrives in.
  assign w_wr        = (r_state == ST_COLLECT) && !i_cand_seen && !i_abort;
  assign w_sample    = (r_state == ST_COLLECT) && !i_abort;
  assign w_prime_inc = (r_state == ST_PRIME) && !i_abort;

  assign w_last_entry = w_wr && (r_fill_cnt == c_FILL_LAST);
  assign w_timeout    = w_sample && ((w_sample_cnt == c_SAMPLE_LAST) || w_sample_max);

  sat_counter #(
    .W   (c_PRIME_W),
    .MAX (PIPE_DEPTH - 1)
  ) u_prime_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_inc (w_prime_inc),
    .o_cnt (w_prime_cnt),
    .o_max (w_prime_max)
  );

  sat_counter #(
    .W   (SAMPLE_W),
    .MAX (MAX_SAMPLES)
  ) u_sample_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_inc (w_sample),
    .o_cnt (w_sample_cnt),
    .o_max (w_sample_max)
  );

  assign w_unused = ^w_prime_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (i_start) w_state_nxt = ST_CLEAR;
        end
        ST_CLEAR: w_state_nxt = ST_PRIME;
        ST_PRIME: begin
          if (w_prime_max) w_state_nxt = ST_COLLECT;
        end
        ST_COLLECT: begin
          // A 256th entry on the final sample completes rather than fails.
          if (w_last_entry)   w_state_nxt = ST_DONE;
          else if (w_timeout) w_state_nxt = ST_FAIL;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
    end else if (w_start_ok) begin
      r_fill_cnt <= '0;
    end else if (w_wr && (r_fill_cnt != c_FILL_FULL)) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  assign o_gen_en     = (r_state == ST_PRIME) || (r_state == ST_COLLECT);
  assign o_seen_clr   = (r_state == ST_CLEAR);
  assign o_wr_en      = w_wr;
  assign o_wr_addr    = r_fill_cnt[SBOX_AW-1:0];
  assign o_busy       = (r_state == ST_CLEAR) || (r_state == ST_PRIME) || (r_state == ST_COLLECT);
  assign o_done       = (r_state == ST_DONE);
  assign o_fail       = (r_state == ST_FAIL);
  assign o_sample_cnt = w_sample_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sbox_gen_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_sbox_gen_ctrl : scoreboard bench for the S-box sequencer         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sbox_gen_ctrl;

  localparam int PIPE_DEPTH  = 3;
  localparam int MAX_SAMPLES = 600;
  localparam int SAMPLE_W    = 16;

  localparam int K_CLR  = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;
  localparam int K_FAIL = 3;

  typedef struct {
    int kind;
    int data;
    int cyc;
  } ev_t;

  ev_t exp_q[$];

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                cand_seen = 1'b0;
  logic                gen_en;
  logic                seen_clr;
  logic                wr_en;
  logic [7:0]          wr_addr;
  logic                busy;
  logic                done;
  logic                fail;
  logic [SAMPLE_W-1:0] sample_cnt;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  sbox_gen_ctrl #(
    .PIPE_DEPTH  (PIPE_DEPTH),
    .MAX_SAMPLES (MAX_SAMPLES),
    .SAMPLE_W    (SAMPLE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_cand_seen  (cand_seen),
    .o_gen_en     (gen_en),
    .o_seen_clr   (seen_clr),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_busy       (busy),
    .o_done       (done),
    .o_fail       (fail),
    .o_sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every observable DUT event must match the head of the queue.
  task automatic mon_event(input int kind, input int data);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d data %0d at cycle %0d, expected none",
               kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (kind == e.kind && data == e.data && cyc == e.cyc) n_pass++;
      else $display("FAIL event: got kind %0d data %0d cycle %0d, expected kind %0d data %0d cycle %0d",
                    kind, data, cyc, e.kind, e.data, e.cyc);
    end
  endtask

  logic prev_done = 1'b0;
  logic prev_fail = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (seen_clr)              mon_event(K_CLR, 0);
      if (wr_en)                 mon_event(K_WR, int'(wr_addr));
      if (done && !prev_done)    mon_event(K_DONE, 0);
      if (fail && !prev_fail)    mon_event(K_FAIL, 0);
    end
    prev_done = done;
    prev_fail = fail;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int mode, input int k, input int nseen);
    case (mode)
      0:       return 1'b0;
      1:       return k[0];
      2:       return 1'b1;
      default: return (k < nseen);
    endcase
  endfunction

  // Starts a run and advances to the first COLLECT cycle.
  task automatic begin_run(input string tag);
    int c0;
    c0 = cyc;
    start = 1'b1;
    exp_q.push_back('{K_CLR, 0, c0 + 1});
    step();
    start = 1'b0;
    check({tag, "_clear_gen_en"}, gen_en, 0);
    check({tag, "_clear_busy"}, busy, 1);
    step();
    check({tag, "_prime_gen_en"}, gen_en, 1);
    check({tag, "_prime_flags"}, {done, fail}, 0);
    repeat (PIPE_DEPTH) step();
  endtask

  task automatic collect(input int mode, input int nseen, input int abort_fill,
                         input bit poke, output int fill, output int samples);
    bit fin;
    fill = 0;
    samples = 0;
    fin = 1'b0;
    for (int k = 0; !fin && k < MAX_SAMPLES + 8; k++) begin
      cand_seen = pat(mode, k, nseen);
      start = poke && (k % 37 == 5);
      if (abort_fill >= 0 && fill == abort_fill && !cand_seen) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        fin = 1'b1;
      end else begin
        samples++;
        if (!cand_seen) begin
          exp_q.push_back('{K_WR, fill, cyc});
          fill++;
        end
        if (fill == 256) begin
          exp_q.push_back('{K_DONE, 0, cyc + 1});
          fin = 1'b1;
        end else if (samples == MAX_SAMPLES) begin
          exp_q.push_back('{K_FAIL, 0, cyc + 1});
          fin = 1'b1;
        end
        step();
      end
    end
    start = 1'b0;
    cand_seen = 1'b0;
  endtask

  task automatic end_checks(input string tag, input int exp_done, input int exp_fail,
                            input int exp_samples);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_fail"}, fail, exp_fail);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_gen_en"}, gen_en, 0);
    check({tag, "_sample_cnt"}, int'(sample_cnt), exp_samples);
  endtask

  initial begin
    int fill;
    int samples;

    repeat (2) step();
    check("reset_flags", {gen_en, seen_clr, wr_en, busy, done, fail}, 0);
    check("reset_addr_cnt", {wr_addr, sample_cnt}, 0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of COLLECT, then idle until a fresh start.
    begin_run("rst");
    for (int k = 0; k < 50; k++) begin
      cand_seen = 1'b0;
      exp_q.push_back('{K_WR, k, cyc});
      step();
    end
    cand_seen = 1'b1;
    check("pre_reset_sample_cnt", int'(sample_cnt), 50);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_reset_flags", {gen_en, seen_clr, wr_en, busy, done, fail}, 0);
    check("midrun_reset_addr_cnt", {wr_addr, sample_cnt}, 0);
    step();
    step();
    rst_n = 1'b1;
    cand_seen = 1'b0;
    repeat (3) step();
    check("post_reset_idle", {gen_en, busy, seen_clr, wr_en}, 0);

    // All-unique stream with stray start pulses during COLLECT.
    begin_run("uniq");
    collect(0, 0, -1, 1'b1, fill, samples);
    end_checks("uniq", 1, 0, 256);

    // Restart from DONE: alternating duplicates.
    begin_run("alt");
    collect(1, 0, -1, 1'b0, fill, samples);
    end_checks("alt", 1, 0, 511);

    // Restart from DONE: every candidate already seen -> timeout.
    begin_run("tmo");
    collect(2, 0, -1, 1'b0, fill, samples);
    end_checks("tmo", 0, 1, MAX_SAMPLES);
    check("tmo_wr_addr", int'(wr_addr), 0);

    // Final sample writes entry 255 only -> still FAIL.
    begin_run("tmo255");
    collect(3, MAX_SAMPLES - 255, -1, 1'b0, fill, samples);
    end_checks("tmo255", 0, 1, MAX_SAMPLES);
    check("tmo255_wr_addr", int'(wr_addr), 255);

    // Final sample writes entry 256 -> DONE wins over FAIL.
    begin_run("edge256");
    collect(3, MAX_SAMPLES - 256, -1, 1'b0, fill, samples);
    end_checks("edge256", 1, 0, MAX_SAMPLES);

    // Abort on the cycle that would write entry 100.
    begin_run("abort");
    collect(0, 0, 100, 1'b0, fill, samples);
    end_checks("abort", 0, 0, 100);
    check("abort_wr_addr_held", int'(wr_addr), 100);
    step();
    check("abort_stays_idle", {busy, gen_en}, 0);

    // Fresh run after abort, then start+abort together in DONE.
    begin_run("rerun");
    collect(0, 0, -1, 1'b0, fill, samples);
    end_checks("rerun", 1, 0, 256);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_flags", {done, fail, busy, gen_en}, 0);
    repeat (3) step();
    check("start_abort_idle", {seen_clr, busy}, 0);

    repeat (2) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
